// File: rtl/sound_fx.sv
// Game audio sequencer: turns eat/failure/success events into short square-wave melodies.
// Success pre-empts failure, failure pre-empts eat; an equal-priority event restarts its melody.
module sound_fx #(
    parameter int CLK_HZ      = 25_175_000,
    parameter int UNIT_CYCLES = 393_359
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_eat,
    input  logic i_failure,
    input  logic i_success,
    input  logic i_mute,
    output logic o_audio,
    output logic o_busy
);

    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [UW-1:0] PRE_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [UW-1:0] PRE_ZERO = UW'(0);
    localparam logic [UW-1:0] PRE_ONE  = UW'(1);

    function automatic int half_of(input int freq);
        return CLK_HZ / (2 * freq);
    endfunction

    localparam int H_1047 = half_of(1047);
    localparam int H_1319 = half_of(1319);
    localparam int H_330  = half_of(330);
    localparam int H_262  = half_of(262);
    localparam int H_220  = half_of(220);
    localparam int H_523  = half_of(523);
    localparam int H_659  = half_of(659);
    localparam int H_784  = half_of(784);

    // The lowest and highest notes bound every other half-period in the ROM.
    if ((H_1319 < 1) || (H_220 > 65535)) begin : g_half_range_bad
        $error("sound_fx: note half-period out of 16-bit range for this CLK_HZ");
    end

    typedef enum logic [1:0] {
        EFF_NONE = 2'd0,
        EFF_EAT  = 2'd1,
        EFF_FAIL = 2'd2,
        EFF_SUCC = 2'd3
    } eff_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state_q;
    eff_t            eff_q;
    logic [1:0]      note_q;
    logic [UW-1:0]   pre_q;
    logic [2:0]      dur_q;
    logic [15:0]     half_q;
    logic            phase_q;
    logic            audio_q;
    logic            busy_q;
    logic            eat_q;
    logic            fail_q;
    logic            succ_q;

    logic            trig_eat_s;
    logic            trig_fail_s;
    logic            trig_succ_s;
    eff_t            new_eff_s;
    logic            restart_s;
    logic [15:0]     cur_half_s;
    logic [2:0]      cur_dur_s;
    logic            last_note_s;
    logic            unit_tick_s;
    logic            half_wrap_s;
    logic            tone_end_s;
    logic            phase_d;

    // Rising-edge detect with fixed priority; only an equal or higher effect may restart.
    always_comb begin
        trig_eat_s  = i_eat & ~eat_q;
        trig_fail_s = i_failure & ~fail_q;
        trig_succ_s = i_success & ~succ_q;
        if (trig_succ_s) begin
            new_eff_s = EFF_SUCC;
        end else if (trig_fail_s) begin
            new_eff_s = EFF_FAIL;
        end else if (trig_eat_s) begin
            new_eff_s = EFF_EAT;
        end else begin
            new_eff_s = EFF_NONE;
        end
        restart_s = (new_eff_s != EFF_NONE) && (new_eff_s >= eff_q);
    end

    // Melody ROM: half-period, duration in units and last-note flag for the current note.
    always_comb begin
        cur_half_s  = 16'd1;
        cur_dur_s   = 3'd1;
        last_note_s = 1'b1;
        case ({eff_q, note_q})
            {EFF_EAT,  2'd0}: begin cur_half_s = 16'(H_1047); cur_dur_s = 3'd2; last_note_s = 1'b0; end
            {EFF_EAT,  2'd1}: begin cur_half_s = 16'(H_1319); cur_dur_s = 3'd2; last_note_s = 1'b1; end
            {EFF_FAIL, 2'd0}: begin cur_half_s = 16'(H_330);  cur_dur_s = 3'd6; last_note_s = 1'b0; end
            {EFF_FAIL, 2'd1}: begin cur_half_s = 16'(H_262);  cur_dur_s = 3'd6; last_note_s = 1'b0; end
            {EFF_FAIL, 2'd2}: begin cur_half_s = 16'(H_220);  cur_dur_s = 3'd6; last_note_s = 1'b1; end
            {EFF_SUCC, 2'd0}: begin cur_half_s = 16'(H_523);  cur_dur_s = 3'd4; last_note_s = 1'b0; end
            {EFF_SUCC, 2'd1}: begin cur_half_s = 16'(H_659);  cur_dur_s = 3'd4; last_note_s = 1'b0; end
            {EFF_SUCC, 2'd2}: begin cur_half_s = 16'(H_784);  cur_dur_s = 3'd4; last_note_s = 1'b0; end
            {EFF_SUCC, 2'd3}: begin cur_half_s = 16'(H_1047); cur_dur_s = 3'd4; last_note_s = 1'b1; end
            default: begin
                cur_half_s  = 16'd1;
                cur_dur_s   = 3'd1;
                last_note_s = 1'b1;
            end
        endcase
    end

    // Timing strobes and next square-wave phase; the phase is forced low outside an ongoing tone.
    always_comb begin
        unit_tick_s = (pre_q == PRE_LAST);
        half_wrap_s = (half_q == (cur_half_s - 16'd1));
        tone_end_s  = unit_tick_s && (dur_q == (cur_dur_s - 3'd1));
        if (!rst_n || restart_s) begin
            phase_d = 1'b0;
        end else if ((state_q == S_TONE) && !tone_end_s) begin
            phase_d = half_wrap_s ? ~phase_q : phase_q;
        end else begin
            phase_d = 1'b0;
        end
    end

    // Edge-detect history tracks the inputs even in reset, so a level held across release is not an event.
    always_ff @(posedge clk) begin
        eat_q  <= i_eat;
        fail_q <= i_failure;
        succ_q <= i_success;
    end

    // Sequencer: note/gap timing, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            eff_q   <= EFF_NONE;
            note_q  <= 2'd0;
            pre_q   <= PRE_ZERO;
            dur_q   <= 3'd0;
            half_q  <= 16'd0;
            phase_q <= 1'b0;
            audio_q <= 1'b0;
            busy_q  <= 1'b0;
        end else if (restart_s) begin
            state_q <= S_TONE;
            eff_q   <= new_eff_s;
            note_q  <= 2'd0;
            pre_q   <= PRE_ZERO;
            dur_q   <= 3'd0;
            half_q  <= 16'd0;
            phase_q <= 1'b0;
            audio_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            phase_q <= phase_d;
            audio_q <= phase_d & ~i_mute;
            case (state_q)
                S_TONE: begin
                    busy_q <= 1'b1;
                    pre_q  <= unit_tick_s ? PRE_ZERO : (pre_q + PRE_ONE);
                    if (tone_end_s) begin
                        state_q <= S_GAP;
                        dur_q   <= 3'd0;
                        half_q  <= 16'd0;
                    end else if (unit_tick_s) begin
                        dur_q  <= dur_q + 3'd1;
                        half_q <= half_wrap_s ? 16'd0 : (half_q + 16'd1);
                    end else begin
                        half_q <= half_wrap_s ? 16'd0 : (half_q + 16'd1);
                    end
                end
                S_GAP: begin
                    half_q <= 16'd0;
                    if (unit_tick_s) begin
                        pre_q <= PRE_ZERO;
                        if (last_note_s) begin
                            state_q <= S_IDLE;
                            eff_q   <= EFF_NONE;
                            note_q  <= 2'd0;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_TONE;
                            note_q  <= note_q + 2'd1;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        pre_q  <= pre_q + PRE_ONE;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    eff_q   <= EFF_NONE;
                    note_q  <= 2'd0;
                    pre_q   <= PRE_ZERO;
                    dur_q   <= 3'd0;
                    half_q  <= 16'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_audio = audio_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_sound_fx.sv
// Directed bench for sound_fx with CLK_HZ=100_000 and UNIT_CYCLES=100 so that every note audibly toggles.
module tb_sound_fx;

    localparam int U = 100;

    logic clk = 1'b0;
    logic rst_n;
    logic i_eat;
    logic i_failure;
    logic i_success;
    logic i_mute;
    logic o_audio;
    logic o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    sound_fx #(.CLK_HZ(100_000), .UNIT_CYCLES(U)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_eat    (i_eat),
        .i_failure(i_failure),
        .i_success(i_success),
        .i_mute   (i_mute),
        .o_audio  (o_audio),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    // Expected audio k cycles after the trigger edge (eff: 1 eat, 2 failure, 3 success).
    function automatic logic exp_audio(input int eff, input int k, input logic muted);
        int halves[4];
        int durs[4];
        int n;
        int t;
        logic res;
        logic done;
        case (eff)
            1:       begin n = 2; halves = '{47, 37, 1, 1};    durs = '{2, 2, 0, 0}; end
            2:       begin n = 3; halves = '{151, 190, 227, 1}; durs = '{6, 6, 6, 0}; end
            3:       begin n = 4; halves = '{95, 75, 63, 47};  durs = '{4, 4, 4, 4}; end
            default: begin n = 0; halves = '{1, 1, 1, 1};      durs = '{0, 0, 0, 0}; end
        endcase
        t = k;
        res = 1'b0;
        done = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (!done) begin
                if (t < durs[i] * U) begin
                    res  = ((t / halves[i]) % 2) == 1;
                    done = 1'b1;
                end else begin
                    t = t - durs[i] * U;
                    if (t < U) begin
                        res  = 1'b0;
                        done = 1'b1;
                    end else begin
                        t = t - U;
                    end
                end
            end
        end
        return muted ? 1'b0 : res;
    endfunction

    // Called at the first negedge after the trigger edge; follows o_busy until it drops (bounded).
    task automatic run_effect(input int eff, input logic muted, input int eat_at,
                              output int busy_n, output int err);
        busy_n = 0;
        err    = 0;
        for (int k = 0; k < 6000; k++) begin
            if (o_busy !== 1'b1) break;
            busy_n++;
            if (o_audio !== exp_audio(eff, k, muted)) err++;
            if (eat_at >= 0) begin
                if (k == eat_at) i_eat = 1'b1;
                else if (k == eat_at + 1) i_eat = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_eat = 1'b0; i_failure = 1'b0; i_success = 1'b0; i_mute = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        n_checks++;
        if (o_audio !== 1'b0) begin n_fail++; $display("FAIL reset_audio: got %b expected 0", o_audio); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy %b expected 0", o_busy); end
    endtask

    task automatic test_eat_pulse();
        int bn, err;
        i_eat = 1'b1; @(negedge clk); i_eat = 1'b0;
        run_effect(1, 1'b0, -1, bn, err);
        n_checks++;
        if (bn !== 600) begin n_fail++; $display("FAIL eat_busy_len: got %0d expected 600", bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL eat_audio: %0d wrong cycles expected 0", err); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_audio !== 1'b0) begin
            n_fail++; $display("FAIL eat_idle: busy %b audio %b expected 0 0", o_busy, o_audio);
        end
    endtask

    task automatic test_eat_held();
        int bn, err;
        i_eat = 1'b1; @(negedge clk);
        run_effect(1, 1'b0, -1, bn, err);
        n_checks++;
        if (bn !== 600) begin n_fail++; $display("FAIL eat_held_len: got %0d expected 600", bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL eat_held_audio: %0d wrong cycles expected 0", err); end
        repeat (20) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL eat_held_retrigger: busy %b expected 0", o_busy); end
        i_eat = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL eat_fall_trigger: busy %b expected 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        int bn, err, pre;
        pre = 0;
        i_eat = 1'b1; @(negedge clk); i_eat = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (o_busy === 1'b1) pre++;
            if (k == 29) i_eat = 1'b1;
            @(negedge clk);
        end
        i_eat = 1'b0;
        run_effect(1, 1'b0, -1, bn, err);
        n_checks++;
        if (pre + bn !== 630) begin n_fail++; $display("FAIL eat_restart_len: got %0d expected 630", pre + bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL eat_restart_audio: %0d wrong cycles expected 0", err); end
    endtask

    task automatic test_preempt_failure();
        int bn, err, pre;
        pre = 0;
        i_eat = 1'b1; @(negedge clk); i_eat = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (o_busy === 1'b1) pre++;
            if (k == 9) i_failure = 1'b1;
            @(negedge clk);
        end
        run_effect(2, 1'b0, -1, bn, err);
        n_checks++;
        if (pre + bn !== 2110) begin n_fail++; $display("FAIL fail_preempt_len: got %0d expected 2110", pre + bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL fail_preempt_audio: %0d wrong cycles expected 0", err); end
    endtask

    task automatic test_failure_ignores_eat();
        int bn, err;
        i_failure = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fail_fall_trigger: busy %b expected 0", o_busy); end
        i_failure = 1'b1; @(negedge clk);
        run_effect(2, 1'b0, 100, bn, err);
        n_checks++;
        if (bn !== 2100) begin n_fail++; $display("FAIL fail_eat_ignored_len: got %0d expected 2100", bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL fail_eat_ignored_audio: %0d wrong cycles expected 0", err); end
    endtask

    task automatic test_success_preempt();
        int bn, err, pre;
        pre = 0;
        i_failure = 1'b0;
        repeat (3) @(negedge clk);
        i_failure = 1'b1; @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (o_busy === 1'b1) pre++;
            if (k == 19) i_success = 1'b1;
            @(negedge clk);
        end
        run_effect(3, 1'b0, -1, bn, err);
        n_checks++;
        if (pre + bn !== 2020) begin n_fail++; $display("FAIL succ_preempt_len: got %0d expected 2020", pre + bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL succ_preempt_audio: %0d wrong cycles expected 0", err); end
    endtask

    task automatic test_simultaneous_mute();
        int bn, err;
        i_failure = 1'b0; i_success = 1'b0;
        repeat (5) @(negedge clk);
        i_mute = 1'b1; @(negedge clk);
        i_eat = 1'b1; i_failure = 1'b1; i_success = 1'b1;
        @(negedge clk);
        i_eat = 1'b0;
        run_effect(3, 1'b1, -1, bn, err);
        n_checks++;
        if (bn !== 2000) begin n_fail++; $display("FAIL simul_mute_len: got %0d expected 2000", bn); end
        n_checks++;
        if (err !== 0) begin n_fail++; $display("FAIL simul_mute_audio: %0d high cycles expected 0", err); end
        i_mute = 1'b0; i_failure = 1'b0; i_success = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid_tone();
        i_eat = 1'b1; @(negedge clk); i_eat = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1 || o_audio !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_tone: busy %b audio %b expected 1 1", o_busy, o_audio);
        end
        rst_n = 1'b0; i_failure = 1'b1;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_audio !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: busy %b audio %b expected 0 0", o_busy, o_audio);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL held_across_reset: busy %b expected 0", o_busy); end
        i_failure = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin n_fail++; $display("FAIL fall_after_reset: busy %b expected 0", o_busy); end
    endtask

    initial begin
        rst_n = 1'b0; i_eat = 1'b0; i_failure = 1'b0; i_success = 1'b0; i_mute = 1'b0;
        @(negedge clk);
        test_reset();
        test_eat_pulse();
        test_eat_held();
        test_back_to_back();
        test_preempt_failure();
        test_failure_ignores_eat();
        test_success_preempt();
        test_simultaneous_mute();
        test_reset_mid_tone();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
